// File: rtl/lc3_ctrl_pkg.sv
// Shared opcode constants, memory-access encoding and decode helpers for the
// LC3 pipeline sequencing controller.
package lc3_ctrl_pkg;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;

    localparam logic [1:0] MEM_READ     = 2'd0;
    localparam logic [1:0] MEM_READ_IND = 2'd1;
    localparam logic [1:0] MEM_WRITE    = 2'd2;
    localparam logic [1:0] MEM_IDLE     = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_IND,
        ST_MEM_READ,
        ST_MEM_WRITE
    } ctrl_state_t;

    // LEA writes a register but is deliberately not a bypass producer.
    function automatic logic is_alu(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
    endfunction

    function automatic logic is_ctrl(input logic [3:0] op);
        return (op == OP_BR) || (op == OP_JMP);
    endfunction

    function automatic logic is_indirect(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_STI);
    endfunction

endpackage

// File: rtl/lc3_bypass_detect.sv
// Register-field compare between the decode and execute instructions; yields
// the next-cycle ALU bypass selects for the two source operands.
module lc3_bypass_detect
    import lc3_ctrl_pkg::*;
(
    input  logic [15:0] ir,
    input  logic [15:0] ir_exec,
    input  logic        exec_valid,
    output logic        bypass_1_next,
    output logic        bypass_2_next
);

    logic producer;
    logic sr2_is_reg;
    logic unused_bits;

    assign unused_bits = ^{ir[11:9], ir[4:3], ir_exec[8:0]};

    always_comb begin
        producer      = exec_valid & is_alu(ir_exec[15:12]);
        // Only the register form of ADD/AND reads sr2; ir[5] selects immediate.
        sr2_is_reg    = ((ir[15:12] == OP_ADD) || (ir[15:12] == OP_AND)) && !ir[5];
        bypass_1_next = producer && (ir[8:6] == ir_exec[11:9]);
        bypass_2_next = producer && sr2_is_reg && (ir[2:0] == ir_exec[11:9]);
    end

endmodule

// File: rtl/lc3_pipeline_controller.sv
// Stage-enable sequencer for the LC3 pipeline: valid shift register, memory
// stall FSM, control-flow fetch bubbles and registered ALU bypass selects.
//
// state        | meaning
// ST_RUN       | pipeline advancing, no memory access pending
// ST_MEM_IND   | indirect pointer read in progress (LDI/STI)
// ST_MEM_READ  | data read in progress, pipeline frozen
// ST_MEM_WRITE | data write in progress, pipeline frozen
module lc3_pipeline_controller
    import lc3_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        complete_data,
    input  logic [15:0] IR,
    input  logic [15:0] IR_Exec,
    input  logic [2:0]  psr,
    output logic        enable_updatePC,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic        br_taken,
    output logic        bypass_alu_1,
    output logic        bypass_alu_2,
    output logic [1:0]  mem_state
);

    ctrl_state_t state;
    logic [3:0]  v;
    logic [1:0]  flush_cnt;
    logic        ind_store;
    logic        stall;
    logic        fetch_ok;
    logic        exec_go;
    logic [3:0]  op_exec;
    logic        bypass_1_next;
    logic        bypass_2_next;

    assign op_exec = IR_Exec[15:12];

    always_comb begin
        stall            = (state != ST_RUN);
        fetch_ok         = (flush_cnt == 2'd0);
        exec_go          = v[2] & ~stall;
        br_taken         = ~reset & exec_go &
                           ((op_exec == OP_JMP) ||
                            ((op_exec == OP_BR) && |(IR_Exec[11:9] & psr)));
        enable_updatePC  = (~reset & fetch_ok & ~stall) | br_taken;
        enable_fetch     = v[0] & ~stall;
        enable_decode    = v[1] & ~stall;
        enable_execute   = v[2] & ~stall;
        enable_writeback = v[3] & ~stall;
    end

    lc3_bypass_detect u_bypass (
        .ir            (IR),
        .ir_exec       (IR_Exec),
        .exec_valid    (v[2]),
        .bypass_1_next (bypass_1_next),
        .bypass_2_next (bypass_2_next)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            v            <= 4'b0000;
            flush_cnt    <= 2'd0;
            bypass_alu_1 <= 1'b0;
            bypass_alu_2 <= 1'b0;
        end else begin
            if (!stall) begin
                v <= {v[2:0], fetch_ok};
                // Fetch stays suppressed while counting, so no reload can land mid-flush.
                if (v[1] && is_ctrl(IR[15:12]))
                    flush_cnt <= 2'd3;
                else if (flush_cnt != 2'd0)
                    flush_cnt <= flush_cnt - 2'd1;
            end
            if (!stall && v[1]) begin
                bypass_alu_1 <= bypass_1_next;
                bypass_alu_2 <= bypass_2_next;
            end else begin
                bypass_alu_1 <= 1'b0;
                bypass_alu_2 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_RUN;
            mem_state <= MEM_IDLE;
            ind_store <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (exec_go && is_indirect(op_exec)) begin
                        state     <= ST_MEM_IND;
                        mem_state <= MEM_READ_IND;
                        ind_store <= (op_exec == OP_STI);
                    end else if (exec_go && is_load(op_exec)) begin
                        state     <= ST_MEM_READ;
                        mem_state <= MEM_READ;
                    end else if (exec_go && is_store(op_exec)) begin
                        state     <= ST_MEM_WRITE;
                        mem_state <= MEM_WRITE;
                    end
                end
                ST_MEM_IND: begin
                    if (complete_data) begin
                        if (ind_store) begin
                            state     <= ST_MEM_WRITE;
                            mem_state <= MEM_WRITE;
                        end else begin
                            state     <= ST_MEM_READ;
                            mem_state <= MEM_READ;
                        end
                    end
                end
                ST_MEM_READ, ST_MEM_WRITE: begin
                    if (complete_data) begin
                        state     <= ST_RUN;
                        mem_state <= MEM_IDLE;
                    end
                end
                default: begin
                    state     <= ST_RUN;
                    mem_state <= MEM_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_pipeline_controller.sv
// Directed cycle-by-cycle bench for lc3_pipeline_controller; the driver queues
// each cycle's expected outputs and a negedge monitor checks them.
module tb_lc3_pipeline_controller;

    localparam logic [15:0] L = 16'hE000; // LEA R0,#0: neither bypass producer nor memory/control

    logic        clock = 1'b0;
    logic        reset;
    logic        complete_data;
    logic [15:0] ir;
    logic [15:0] ir_exec;
    logic [2:0]  psr;
    logic        enable_updatePC, enable_fetch, enable_decode, enable_execute;
    logic        enable_writeback, br_taken, bypass_alu_1, bypass_alu_2;
    logic [1:0]  mem_state;

    typedef struct packed {
        logic        rst;
        logic        cd;
        logic [15:0] ir;
        logic [15:0] ire;
        logic [2:0]  psr;
        logic [9:0]  exp;
    } vec_t;

    typedef struct {
        int         idx;
        logic [9:0] exp;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    lc3_pipeline_controller dut (
        .clock            (clock),
        .reset            (reset),
        .complete_data    (complete_data),
        .IR               (ir),
        .IR_Exec          (ir_exec),
        .psr              (psr),
        .enable_updatePC  (enable_updatePC),
        .enable_fetch     (enable_fetch),
        .enable_decode    (enable_decode),
        .enable_execute   (enable_execute),
        .enable_writeback (enable_writeback),
        .br_taken         (br_taken),
        .bypass_alu_1     (bypass_alu_1),
        .bypass_alu_2     (bypass_alu_2),
        .mem_state        (mem_state)
    );

    always #5 clock = ~clock;

    // flags = {updatePC, fetch, decode, execute, writeback, br_taken, bypass1, bypass2}
    task automatic add(input logic r, input logic c, input logic [15:0] i,
                       input logic [15:0] e, input logic [2:0] p,
                       input logic [7:0] flags, input logic [1:0] ms);
        vec_t t;
        t.rst = r; t.cd = c; t.ir = i; t.ire = e; t.psr = p; t.exp = {flags, ms};
        vecs.push_back(t);
    endtask

    initial begin
        // reset release ramp, then ADD R1,R1,R2 -> ADD R3,R1,R4
        add(0, 0, L,       L,       3'b000, 8'b1000_0000, 2'd3); // 0
        add(0, 0, L,       L,       3'b000, 8'b1100_0000, 2'd3);
        add(0, 0, L,       L,       3'b000, 8'b1110_0000, 2'd3);
        add(0, 0, L,       L,       3'b000, 8'b1111_0000, 2'd3);
        add(0, 0, 16'h1644, 16'h1242, 3'b000, 8'b1111_1000, 2'd3);
        add(0, 0, L,       16'h1644, 3'b000, 8'b1111_1010, 2'd3); // 5: bypass1
        add(0, 0, L,       L,       3'b000, 8'b1111_1000, 2'd3);
        // LDR, completes in second stall cycle
        add(0, 0, L,       16'h6400, 3'b000, 8'b1111_1000, 2'd3);
        add(0, 0, L,       L,       3'b000, 8'b0000_0000, 2'd0);
        add(0, 1, L,       L,       3'b000, 8'b0000_0000, 2'd0);
        add(0, 0, L,       L,       3'b000, 8'b1111_1000, 2'd3); // 10
        // STI with complete_data already high
        add(0, 1, L,       16'hB000, 3'b000, 8'b1111_1000, 2'd3);
        add(0, 1, L,       L,       3'b000, 8'b0000_0000, 2'd1);
        add(0, 1, L,       L,       3'b000, 8'b0000_0000, 2'd2);
        add(0, 0, L,       L,       3'b000, 8'b1111_1000, 2'd3);
        // BRz, Z set: taken
        add(0, 0, 16'h0400, L,      3'b010, 8'b1111_1000, 2'd3); // 15
        add(0, 0, L,       16'h0400, 3'b010, 8'b1111_1100, 2'd3);
        add(0, 0, L,       L,       3'b010, 8'b0011_1000, 2'd3);
        add(0, 0, L,       L,       3'b010, 8'b0001_1000, 2'd3);
        add(0, 0, L,       L,       3'b010, 8'b1000_1000, 2'd3);
        add(0, 0, L,       L,       3'b010, 8'b1100_0000, 2'd3); // 20
        add(0, 0, L,       L,       3'b010, 8'b1110_0000, 2'd3);
        add(0, 0, L,       L,       3'b010, 8'b1111_0000, 2'd3);
        add(0, 0, L,       L,       3'b010, 8'b1111_1000, 2'd3);
        // BRz, N set: not taken, still three bubbles
        add(0, 0, 16'h0400, L,      3'b100, 8'b1111_1000, 2'd3);
        add(0, 0, L,       16'h0400, 3'b100, 8'b0111_1000, 2'd3); // 25
        add(0, 0, L,       L,       3'b100, 8'b0011_1000, 2'd3);
        add(0, 0, L,       L,       3'b100, 8'b0001_1000, 2'd3);
        add(0, 0, L,       L,       3'b100, 8'b1000_1000, 2'd3);
        add(0, 0, L,       L,       3'b100, 8'b1100_0000, 2'd3);
        add(0, 0, L,       L,       3'b100, 8'b1110_0000, 2'd3); // 30
        add(0, 0, L,       L,       3'b100, 8'b1111_0000, 2'd3);
        // ADD R2,R0,#5 then AND R1,R3,R2 (register sr2) and AND R1,R3,#2 (immediate)
        add(0, 0, 16'h52C2, 16'h1425, 3'b000, 8'b1111_1000, 2'd3);
        add(0, 0, 16'h52E2, 16'h1425, 3'b000, 8'b1111_1001, 2'd3);
        add(0, 0, L,       L,       3'b000, 8'b1111_1000, 2'd3);
        // LD then reset while in MEM_READ; ramp repeats
        add(0, 0, L,       16'h2000, 3'b000, 8'b1111_1000, 2'd3); // 35
        add(1, 0, L,       L,       3'b000, 8'b0000_0000, 2'd0);
        add(0, 0, L,       L,       3'b000, 8'b1000_0000, 2'd3);
        add(0, 0, L,       L,       3'b000, 8'b1100_0000, 2'd3);
        add(0, 0, L,       L,       3'b000, 8'b1110_0000, 2'd3);
        add(0, 0, L,       L,       3'b000, 8'b1111_0000, 2'd3); // 40
        add(0, 0, L,       L,       3'b000, 8'b1111_1000, 2'd3);

        reset = 1'b1; complete_data = 1'b0; ir = L; ir_exec = L; psr = 3'b000;
        repeat (2) @(posedge clock);
        #1;
        foreach (vecs[k]) begin
            exp_t e;
            reset         = vecs[k].rst;
            complete_data = vecs[k].cd;
            ir            = vecs[k].ir;
            ir_exec       = vecs[k].ire;
            psr           = vecs[k].psr;
            e.idx = k;
            e.exp = vecs[k].exp;
            exp_q.push_back(e);
            @(posedge clock);
            #1;
        end
        repeat (2) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [9:0] act;
            e = exp_q.pop_front();
            act = {enable_updatePC, enable_fetch, enable_decode, enable_execute,
                   enable_writeback, br_taken, bypass_alu_1, bypass_alu_2, mem_state};
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL cyc%0d {upc,f,d,e,w,br,b1,b2,ms}: got %b_%b required %b_%b",
                         e.idx, act[9:2], act[1:0], e.exp[9:2], e.exp[1:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
